// File: rtl/sum_frame_accumulator.sv
// sum_frame_accumulator: accumulates adder sums into saturating frame totals with valid/ready in and out.
module sum_frame_accumulator #(
  parameter int IN_W      = 2,
  parameter int ACC_W     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_W-1:0]                in_sum,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_acc,
  output logic [$clog2(FRAME_LEN+1)-1:0] out_cnt,
  output logic                           out_sat,
  output logic                           busy
);
  localparam int CW = $clog2(FRAME_LEN+1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic sat_q, sat_d, accept, xfer, ovf;
  logic [ACC_W:0] sum;
  // acc_q is always zero in IDLE, so one adder serves both the first and later samples
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
  assign ovf = sum[ACC_W];
  assign cnt_n = cnt_q + CW'(1);
  assign in_ready = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign accept = in_valid & in_ready;
  assign xfer = out_valid & out_ready;
  assign out_acc = out_valid ? acc_q : '0;
  assign out_cnt = out_valid ? cnt_q : '0;
  assign out_sat = out_valid & sat_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (accept) begin
      acc_d = ovf ? '1 : sum[ACC_W-1:0];
      cnt_d = cnt_n;
      sat_d = sat_q | ovf;
      state_d = (cnt_n == CW'(FRAME_LEN) || flush) ? HOLD : ACCUM;
    end else if (state_q == ACCUM && flush) begin
      state_d = HOLD;
    end
    if (xfer) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_sum_frame_accumulator.sv
// tb_sum_frame_accumulator: directed checks of framing, back-pressure, saturation, flush and reset.
module tb_sum_frame_accumulator;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [1:0] in_sum = '0;
  logic in_ready, out_valid, out_sat, busy;
  logic [7:0] out_acc;
  logic [2:0] out_cnt;
  logic v3 = 1'b0, f3 = 1'b0, r3 = 1'b0;
  logic [1:0] s3 = '0;
  logic in_ready3, out_valid3, out_sat3, busy3;
  logic [2:0] out_acc3, out_cnt3;
  logic [14:0] st, exp_st;
  logic [9:0] st3, exp_st3;
  int n_checks = 0, n_fail = 0;

  // status word: {out_valid, in_ready, busy, out_sat, out_cnt, out_acc}
  assign st = {out_valid, in_ready, busy, out_sat, out_cnt, out_acc};
  assign st3 = {out_valid3, in_ready3, busy3, out_sat3, out_cnt3, out_acc3};

  always #5 clk = ~clk;

  sum_frame_accumulator #(.IN_W(2), .ACC_W(8), .FRAME_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_cnt(out_cnt), .out_sat(out_sat), .busy(busy)
  );

  sum_frame_accumulator #(.IN_W(2), .ACC_W(3), .FRAME_LEN(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(in_ready3), .in_sum(s3),
    .flush(f3), .out_valid(out_valid3), .out_ready(r3), .out_acc(out_acc3),
    .out_cnt(out_cnt3), .out_sat(out_sat3), .busy(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic f);
    in_valid = 1'b1;
    in_sum = s;
    flush = f;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send3(input logic [1:0] s);
    v3 = 1'b1;
    s3 = s;
    step();
    v3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL reset: status=%h expected=%h", st, exp_st); end
    exp_st3 = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};
    n_checks++;
    if (st3 !== exp_st3) begin n_fail++; $display("FAIL reset_acc3: status=%h expected=%h", st3, exp_st3); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    send(2'd1, 1'b0);
    exp_st = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL b2b_mid: status=%h expected=%h", st, exp_st); end
    send(2'd0, 1'b0);
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'd4};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL b2b_result: status=%h expected=%h", st, exp_st); end
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL b2b_idle: status=%h expected=%h", st, exp_st); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'd2, 1'b0);
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'd8};
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (st !== exp_st) begin n_fail++; $display("FAIL hold_cycle%0d: status=%h expected=%h", i, st, exp_st); end
      in_valid = i[0];
      in_sum = 2'd3;
      flush = ~i[0];
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL hold_end: status=%h expected=%h", st, exp_st); end
    out_ready = 1'b1;
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL hold_release: status=%h expected=%h", st, exp_st); end
  endtask

  task automatic test_saturation();
    r3 = 1'b1;
    for (int i = 0; i < 4; i++) send3(2'd2);
    exp_st3 = {1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 3'd7};
    n_checks++;
    if (st3 !== exp_st3) begin n_fail++; $display("FAIL sat_frame: status=%h expected=%h", st3, exp_st3); end
    step();
    send3(2'd1);
    for (int i = 0; i < 3; i++) send3(2'd0);
    exp_st3 = {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 3'd1};
    n_checks++;
    if (st3 !== exp_st3) begin n_fail++; $display("FAIL sat_cleared: status=%h expected=%h", st3, exp_st3); end
    step();
    exp_st3 = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};
    n_checks++;
    if (st3 !== exp_st3) begin n_fail++; $display("FAIL sat_idle: status=%h expected=%h", st3, exp_st3); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(2'd1, 1'b0);
    send(2'd1, 1'b1);
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd2};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL flush_with_accept: status=%h expected=%h", st, exp_st); end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL flush_idle: status=%h expected=%h", st, exp_st); end
    out_ready = 1'b0;
    send(2'd2, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'd2};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL flush_alone_accum: status=%h expected=%h", st, exp_st); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL reset_mid: status=%h expected=%h", st, exp_st); end
    for (int i = 0; i < 4; i++) send(2'd1, 1'b0);
    exp_st = {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'd4};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL after_reset_frame: status=%h expected=%h", st, exp_st); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
    n_checks++;
    if (st !== exp_st) begin n_fail++; $display("FAIL reset_hold: status=%h expected=%h", st, exp_st); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_flush();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
